// File: rtl/fetch_wf_scheduler.sv
// Round-robin fetch scheduler: tracks per-wavefront PC and fetch state, issues one
// {first, wfid, pc} fetch tag per slot, and flags returns made stale by redirect/halt.
module fetch_wf_scheduler #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6,
    parameter int PC_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 disp_valid,
    input  logic [WFID_W-1:0]    disp_wfid,
    input  logic [PC_W-1:0]      disp_pc,
    input  logic                 halt_valid,
    input  logic [WFID_W-1:0]    halt_wfid,
    input  logic                 redir_valid,
    input  logic [WFID_W-1:0]    redir_wfid,
    input  logic [PC_W-1:0]      redir_pc,
    input  logic [NUM_WF-1:0]    pool_vacant,
    input  logic                 fetch_ready,
    input  logic                 buff_ack,
    input  logic [WFID_W-1:0]    ack_wfid,
    output logic                 fetch_valid,
    output logic [PC_W+WFID_W:0] fetch_tag,
    output logic                 squash_valid,
    output logic [WFID_W-1:0]    squash_wfid
);
    // Handshake: a tag transfers on every rising edge where fetch_valid and fetch_ready are
    // both high; while fetch_valid is high and fetch_ready low, fetch_tag is held unchanged.

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READY   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_WAIT_SQ = 2'd3
    } slot_state_e;

    slot_state_e             state_q [NUM_WF];
    slot_state_e             state_d [NUM_WF];
    logic [PC_W-1:0]         pc_q    [NUM_WF];
    logic [PC_W-1:0]         pc_d    [NUM_WF];
    logic [NUM_WF-1:0]       first_q, first_d;
    logic [NUM_WF-1:0]       halted_q, halted_d;
    logic                    fetch_valid_q, fetch_valid_d;
    logic [PC_W+WFID_W:0]    fetch_tag_q, fetch_tag_d;
    logic [WFID_W-1:0]       rr_q, rr_d;
    logic                    squash_valid_q, squash_valid_d;
    logic [WFID_W-1:0]       squash_wfid_q, squash_wfid_d;

    logic [NUM_WF-1:0]       disp_hit, halt_hit, redir_hit, ack_hit, eligible;
    logic [WFID_W-1:0]       held_wfid;
    logic                    arb_en, grant_found;
    int                      grant_idx, idx;

    assign held_wfid = fetch_tag_q[PC_W +: WFID_W];
    assign arb_en    = !fetch_valid_q || fetch_ready;

    // wfids at or above NUM_WF match no slot, so they fall out as ignored
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            disp_hit[i]  = disp_valid  && (disp_wfid  == WFID_W'(i));
            halt_hit[i]  = halt_valid  && (halt_wfid  == WFID_W'(i));
            redir_hit[i] = redir_valid && (redir_wfid == WFID_W'(i));
            ack_hit[i]   = buff_ack    && (ack_wfid   == WFID_W'(i));
            eligible[i]  = (state_q[i] == ST_READY) && pool_vacant[i] &&
                           !halt_hit[i] && !redir_hit[i] &&
                           !(fetch_valid_q && (held_wfid == WFID_W'(i)));
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        first_d        = first_q;
        halted_d       = halted_q;
        fetch_valid_d  = fetch_valid_q;
        fetch_tag_d    = fetch_tag_q;
        rr_d           = rr_q;
        squash_valid_d = 1'b0;
        squash_wfid_d  = squash_wfid_q;
        grant_found    = 1'b0;
        grant_idx      = 0;
        idx            = 0;

        for (int i = 0; i < NUM_WF; i++) begin
            case (state_q[i])
                ST_IDLE: begin
                    if (disp_hit[i]) begin
                        state_d[i]  = ST_READY;
                        pc_d[i]     = disp_pc;
                        first_d[i]  = 1'b1;
                        halted_d[i] = 1'b0;
                    end
                end
                ST_READY: begin
                    if (halt_hit[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (redir_hit[i]) begin
                        pc_d[i] = redir_pc;
                    end
                end
                ST_WAIT, ST_WAIT_SQ: begin
                    if (halt_hit[i]) begin
                        halted_d[i] = 1'b1;
                    end else if (redir_hit[i]) begin
                        pc_d[i] = redir_pc;
                    end
                    // An ack is only genuine if nothing made the outstanding fetch stale
                    if (ack_hit[i]) begin
                        if (state_q[i] == ST_WAIT && !halt_hit[i] && !redir_hit[i]) begin
                            state_d[i] = ST_READY;
                            pc_d[i]    = pc_q[i] + PC_W'(4);
                            first_d[i] = 1'b0;
                        end else begin
                            squash_valid_d = 1'b1;
                            squash_wfid_d  = ack_wfid;
                            if (halted_q[i] || halt_hit[i]) begin
                                state_d[i]  = ST_IDLE;
                                halted_d[i] = 1'b0;
                            end else begin
                                state_d[i] = ST_READY;
                            end
                        end
                    end else if (halt_hit[i] || redir_hit[i]) begin
                        state_d[i] = ST_WAIT_SQ;
                    end
                end
                default: ;
            endcase
        end

        if (arb_en) begin
            for (int k = 0; k < NUM_WF; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_WF) begin
                    idx = idx - NUM_WF;
                end
                if (!grant_found && eligible[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = idx;
                end
            end
            fetch_valid_d = grant_found;
            if (grant_found) begin
                state_d[grant_idx] = ST_WAIT;
                fetch_tag_d        = {first_q[grant_idx], WFID_W'(grant_idx), pc_q[grant_idx]};
                rr_d               = (grant_idx == NUM_WF - 1) ? '0 : WFID_W'(grant_idx + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                state_q[i] <= ST_IDLE;
                pc_q[i]    <= '0;
            end
            first_q        <= '0;
            halted_q       <= '0;
            fetch_valid_q  <= 1'b0;
            fetch_tag_q    <= '0;
            rr_q           <= '0;
            squash_valid_q <= 1'b0;
            squash_wfid_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            first_q        <= first_d;
            halted_q       <= halted_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_tag_q    <= fetch_tag_d;
            rr_q           <= rr_d;
            squash_valid_q <= squash_valid_d;
            squash_wfid_q  <= squash_wfid_d;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign fetch_tag    = fetch_tag_q;
    assign squash_valid = squash_valid_q;
    assign squash_wfid  = squash_wfid_q;
endmodule

// File: tb/tb_fetch_wf_scheduler.sv
// Bench for fetch_wf_scheduler: directed scenarios with literal expectations, then random
// traffic compared every cycle against a slot-occupancy model of the scheduling rules.
module tb_fetch_wf_scheduler;
    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;
    localparam int PC_W   = 32;

    logic                 clk;
    logic                 rst;
    logic                 disp_valid;
    logic [WFID_W-1:0]    disp_wfid;
    logic [PC_W-1:0]      disp_pc;
    logic                 halt_valid;
    logic [WFID_W-1:0]    halt_wfid;
    logic                 redir_valid;
    logic [WFID_W-1:0]    redir_wfid;
    logic [PC_W-1:0]      redir_pc;
    logic [NUM_WF-1:0]    pool_vacant;
    logic                 fetch_ready;
    logic                 buff_ack;
    logic [WFID_W-1:0]    ack_wfid;
    logic                 fetch_valid;
    logic [38:0]          fetch_tag;
    logic                 squash_valid;
    logic [WFID_W-1:0]    squash_wfid;

    fetch_wf_scheduler #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_wfid(disp_wfid), .disp_pc(disp_pc),
        .halt_valid(halt_valid), .halt_wfid(halt_wfid),
        .redir_valid(redir_valid), .redir_wfid(redir_wfid), .redir_pc(redir_pc),
        .pool_vacant(pool_vacant), .fetch_ready(fetch_ready),
        .buff_ack(buff_ack), .ack_wfid(ack_wfid),
        .fetch_valid(fetch_valid), .fetch_tag(fetch_tag),
        .squash_valid(squash_valid), .squash_wfid(squash_wfid)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit auto_ack = 1'b0;
    logic [WFID_W-1:0] acc_q[$];
    logic [WFID_W-1:0] acc_log[$];
    logic [WFID_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A slot is occupied while live (dispatched, not retired) or busy (fetch outstanding);
    // stale marks an outstanding fetch whose return must be dropped.
    bit              m_live  [NUM_WF];
    bit              m_busy  [NUM_WF];
    bit              m_stale [NUM_WF];
    bit              m_first [NUM_WF];
    logic [PC_W-1:0] m_pc    [NUM_WF];
    bit              m_fetch_valid;
    logic [38:0]     m_tag;
    int              m_rr;
    bit              m_sq_valid;
    logic [5:0]      m_sq_wfid;

    always @(posedge clk) begin : model
        int h, r, a, d, w, c;
        bit pre_occ_d, sq;
        if (!rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                m_live[i] = 0; m_busy[i] = 0; m_stale[i] = 0; m_first[i] = 0; m_pc[i] = '0;
            end
            m_fetch_valid = 0; m_tag = '0; m_rr = 0; m_sq_valid = 0; m_sq_wfid = '0;
        end else begin
            h = (halt_valid  && halt_wfid  < NUM_WF) ? int'(halt_wfid)  : -1;
            r = (redir_valid && redir_wfid < NUM_WF) ? int'(redir_wfid) : -1;
            a = (buff_ack    && ack_wfid   < NUM_WF) ? int'(ack_wfid)   : -1;
            d = (disp_valid  && disp_wfid  < NUM_WF) ? int'(disp_wfid)  : -1;
            w = -1;
            sq = 0;
            if (!m_fetch_valid || fetch_ready) begin
                for (int k = 0; k < NUM_WF; k++) begin
                    c = (m_rr + k) % NUM_WF;
                    if (w < 0 && m_live[c] && !m_busy[c] && pool_vacant[c] && c != h && c != r &&
                        !(m_fetch_valid && int'(m_tag[37:32]) == c))
                        w = c;
                end
            end
            pre_occ_d = (d >= 0) && (m_live[d] || m_busy[d]);
            if (h >= 0) begin
                if (m_busy[h]) m_stale[h] = 1;
                m_live[h] = 0;
            end
            if (r >= 0 && r != h && (m_live[r] || m_busy[r])) begin
                m_pc[r] = redir_pc;
                if (m_busy[r]) m_stale[r] = 1;
            end
            if (a >= 0 && m_busy[a]) begin
                if (m_stale[a]) begin
                    sq = 1;
                end else begin
                    m_pc[a] = m_pc[a] + 32'd4;
                    m_first[a] = 0;
                end
                m_busy[a] = 0;
                m_stale[a] = 0;
            end
            if (d >= 0 && !pre_occ_d) begin
                m_live[d] = 1; m_pc[d] = disp_pc; m_first[d] = 1;
            end
            if (!m_fetch_valid || fetch_ready) begin
                if (w >= 0) begin
                    m_tag = {m_first[w], 6'(w), m_pc[w]};
                    m_busy[w] = 1;
                    m_fetch_valid = 1;
                    m_rr = (w + 1) % NUM_WF;
                end else begin
                    m_fetch_valid = 0;
                end
            end
            m_sq_valid = sq;
            if (sq) m_sq_wfid = 6'(a);
        end
    end

    // Record accepted fetches so the driver can return them
    always @(posedge clk) begin
        if (rst && fetch_valid && fetch_ready) begin
            acc_q.push_back(fetch_tag[37:32]);
            acc_log.push_back(fetch_tag[37:32]);
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("fetch_valid", {63'd0, fetch_valid}, {63'd0, m_fetch_valid});
            if (m_fetch_valid) check("fetch_tag", {25'd0, fetch_tag}, {25'd0, m_tag});
            check("squash_valid", {63'd0, squash_valid}, {63'd0, m_sq_valid});
            if (m_sq_valid) check("squash_wfid", {58'd0, squash_wfid}, {58'd0, m_sq_wfid});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        disp_valid = 0; halt_valid = 0; redir_valid = 0; buff_ack = 0;
        if (auto_ack && acc_q.size() > 0) begin
            buff_ack = 1;
            ack_wfid = acc_q.pop_front();
        end
    endtask

    task automatic do_reset();
        rst = 0; disp_valid = 0; halt_valid = 0; redir_valid = 0; buff_ack = 0;
        disp_wfid = '0; disp_pc = '0; halt_wfid = '0; redir_wfid = '0; redir_pc = '0;
        ack_wfid = '0; pool_vacant = '1; fetch_ready = 0; auto_ack = 0;
        step();
        chk_en = 1;
        check("reset_fetch_valid", {63'd0, fetch_valid}, 64'd0);
        check("reset_fetch_tag", {25'd0, fetch_tag}, 64'd0);
        check("reset_squash_valid", {63'd0, squash_valid}, 64'd0);
        check("reset_squash_wfid", {58'd0, squash_wfid}, 64'd0);
        step();
        rst = 1;
        acc_q.delete();
        acc_log.delete();
    endtask

    task automatic dispatch(input int wf, input logic [31:0] pc);
        disp_valid = 1; disp_wfid = 6'(wf); disp_pc = pc;
    endtask

    task automatic ack(input int wf);
        buff_ack = 1; ack_wfid = 6'(wf);
    endtask

    function automatic logic [5:0] rand_wfid();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return 6'($urandom_range(0, 7));
        if (r < 9) return 6'($urandom_range(0, NUM_WF - 1));
        return 6'($urandom_range(NUM_WF, 63));
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF8;
        return $urandom & 32'hFFFF_FFFC;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int j;
        // 1: first fetch after dispatch, then PC advance on ack
        do_reset();
        dispatch(3, 32'h100);
        step();
        step();
        check("t1_valid", {63'd0, fetch_valid}, 64'd1);
        check("t1_tag_first", {25'd0, fetch_tag}, 64'h43_0000_0100);
        check("t1_model_pin", {25'd0, m_tag}, 64'h43_0000_0100);
        fetch_ready = 1;
        step();
        ack(3);
        step();
        step();
        check("t1_tag_next", {25'd0, fetch_tag}, 64'h03_0000_0104);
        check("t1_model_pin2", {25'd0, m_tag}, 64'h03_0000_0104);

        // 2: round-robin order with immediate acks
        do_reset();
        fetch_ready = 1;
        auto_ack = 1;
        dispatch(1, 32'h1000); step();
        dispatch(5, 32'h5000); step();
        dispatch(7, 32'h7000); step();
        repeat (8) step();
        fetch_ready = 0;
        auto_ack = 0;
        exp_q = '{6'd1, 6'd5, 6'd7, 6'd1, 6'd5, 6'd7};
        check("t2_count", {63'd0, acc_log.size() >= 6}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("t2_grant_order", {58'd0, (i < acc_log.size()) ? acc_log[i] : 6'h3f},
                  {58'd0, exp_q[i]});
        end

        // 3: hold under back-pressure, pool_vacant gating
        do_reset();
        dispatch(2, 32'h200);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_valid", {63'd0, fetch_valid}, 64'd1);
            check("t3_hold_tag", {25'd0, fetch_tag}, 64'h42_0000_0200);
        end
        fetch_ready = 1;
        step();
        pool_vacant[2] = 0;
        ack(2);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_blocked", {63'd0, fetch_valid}, 64'd0);
        end
        pool_vacant[2] = 1;
        step();
        check("t3_regrant", {25'd0, fetch_tag}, 64'h02_0000_0204);

        // 4: redirect while waiting, then squashed ack
        do_reset();
        fetch_ready = 1;
        dispatch(4, 32'h400);
        step();
        step();
        step();
        ack(4);
        step();
        step();
        check("t4_second_tag", {25'd0, fetch_tag}, 64'h04_0000_0404);
        step();
        redir_valid = 1; redir_wfid = 6'd4; redir_pc = 32'h800;
        step();
        ack(4);
        step();
        check("t4_squash_valid", {63'd0, squash_valid}, 64'd1);
        check("t4_squash_wfid", {58'd0, squash_wfid}, 64'd4);
        step();
        check("t4_squash_pulse", {63'd0, squash_valid}, 64'd0);
        check("t4_redir_tag", {25'd0, fetch_tag}, 64'h04_0000_0800);

        // 5: halt of the held wavefront
        do_reset();
        dispatch(6, 32'h600);
        step();
        step();
        halt_valid = 1; halt_wfid = 6'd6;
        step();
        check("t5_held_tag", {25'd0, fetch_tag}, 64'h46_0000_0600);
        step();
        check("t5_held_tag2", {25'd0, fetch_tag}, 64'h46_0000_0600);
        fetch_ready = 1;
        step();
        ack(6);
        step();
        check("t5_squash_valid", {63'd0, squash_valid}, 64'd1);
        check("t5_squash_wfid", {58'd0, squash_wfid}, 64'd6);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t5_never_again", {63'd0, fetch_valid}, 64'd0);
        end

        // 6: pointer wrap past the last slot; redirect+ack in the same cycle
        do_reset();
        dispatch(39, 32'h3900);
        step();
        step();
        check("t6_tag39", {25'd0, fetch_tag}, 64'h67_0000_3900);
        dispatch(0, 32'h10); step();
        dispatch(38, 32'h3800); step();
        fetch_ready = 1;
        step();
        check("t6_wrap_to_0", {25'd0, fetch_tag}, 64'h40_0000_0010);
        step();
        check("t6_then_38", {25'd0, fetch_tag}, 64'h66_0000_3800);
        redir_valid = 1; redir_wfid = 6'd39; redir_pc = 32'h2000;
        ack(39);
        step();
        check("t6_squash_valid", {63'd0, squash_valid}, 64'd1);
        check("t6_squash_wfid", {58'd0, squash_wfid}, 64'd39);
        step();
        check("t6_redir_tag", {25'd0, fetch_tag}, 64'h67_0000_2000);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            step();
            rst = ($urandom_range(0, 599) != 0);
            if (!rst) acc_log.delete();
            fetch_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_WF; i++) pool_vacant[i] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) begin
                disp_valid = 1; disp_wfid = rand_wfid(); disp_pc = rand_pc();
            end
            if ($urandom_range(0, 19) == 0) begin
                halt_valid = 1; halt_wfid = rand_wfid();
            end
            if ($urandom_range(0, 9) == 0) begin
                redir_valid = 1; redir_wfid = rand_wfid(); redir_pc = rand_pc();
            end
            if (acc_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                j = int'($urandom_range(0, acc_q.size() - 1));
                buff_ack = 1;
                ack_wfid = acc_q[j];
                acc_q.delete(j);
            end else if ($urandom_range(0, 24) == 0) begin
                buff_ack = 1;
                ack_wfid = rand_wfid();
            end
        end
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
